// File: rtl/sprite_blit_writer.sv
// sprite_blit_writer
//   Write-side blitter: takes a rectangle command and a row-major stream of palette-index
//   pixels, generates frame-buffer addresses (y*FB_WIDTH+x) and drives the frame-buffer
//   RAM write port with one cycle of latency. Pixels outside the frame buffer are
//   consumed but not written.
//
//   Optional feature macro: TRANSPARENT_SKIP_EN
//     defined   -> pixels equal to TRANSPARENT are consumed without a write
//     undefined -> every in-bounds pixel is written
//
// Ports
//   Clk, Reset            clock (posedge) and asynchronous active-high reset
//   cmd_valid/cmd_ready   rectangle command handshake (ready only when idle)
//   cmd_x/cmd_y/cmd_w/cmd_h  top-left corner and size (zero width/height allowed)
//   pix_valid/pix_ready   pixel stream handshake (ready only while streaming)
//   pix_data              palette index
//   wr_en/wr_addr/wr_data frame-buffer write port
//   busy                  high whenever a command is in progress
//   done                  one-cycle completion pulse, always after the final write
module sprite_blit_writer #(
   parameter int unsigned       DATA_W      = 5,
   parameter int unsigned       ADDR_W      = 19,
   parameter int unsigned       FB_WIDTH    = 640,
   parameter int unsigned       FB_HEIGHT   = 480,
   parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [9:0]        cmd_x,
   input  logic [8:0]        cmd_y,
   input  logic [9:0]        cmd_w,
   input  logic [8:0]        cmd_h,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   // StDrain holds off done for one cycle so it never coincides with the last write.
   typedef enum logic [2:0] {StIdle, StSetup, StStream, StDrain, StDone} state_e;

   localparam logic [10:0]       FbW11   = 11'(FB_WIDTH);
   localparam logic [10:0]       FbH11   = 11'(FB_HEIGHT);
   localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(FB_WIDTH);

   state_e              state_q, state_d;
   logic [9:0]          x_q, x_d, w_q, w_d, col_q, col_d;
   logic [8:0]          y_q, y_d, h_q, h_d, row_q, row_d;
   logic [ADDR_W-1:0]   row_base_q, row_base_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;

   logic                hs, col_last, row_last, in_bounds, opaque;
   logic [10:0]         abs_x, abs_y;

   assign hs       = pix_valid && (state_q == StStream);
   assign col_last = (col_q == w_q - 10'd1);
   assign row_last = (row_q == h_q - 9'd1);

   // 11-bit sums so a rectangle hanging off the right/bottom edge cannot wrap back in.
   assign abs_x     = 11'(x_q) + 11'(col_q);
   assign abs_y     = 11'(y_q) + 11'(row_q);
   assign in_bounds = (abs_x < FbW11) && (abs_y < FbH11);

`ifdef TRANSPARENT_SKIP_EN
   assign opaque = (pix_data != TRANSPARENT);
`else
   logic unused_transparent;
   assign unused_transparent = ^TRANSPARENT;
   assign opaque             = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      w_d        = w_q;
      h_d        = h_q;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               x_d     = cmd_x;
               y_d     = cmd_y;
               w_d     = cmd_w;
               h_d     = cmd_h;
               state_d = StSetup;
            end
         end
         StSetup: begin
            row_base_d = ADDR_W'(32'(y_q) * FB_WIDTH + 32'(x_q));
            col_d      = '0;
            row_d      = '0;
            state_d    = (w_q == '0 || h_q == '0) ? StDone : StStream;
         end
         StStream: begin
            if (hs) begin
               wr_en_d   = in_bounds && opaque;
               wr_addr_d = row_base_q + ADDR_W'(col_q);
               wr_data_d = pix_data;
               if (col_last) begin
                  col_d      = '0;
                  row_d      = row_q + 9'd1;
                  row_base_d = row_base_q + RowStep;
                  if (row_last) state_d = StDrain;
               end else begin
                  col_d = col_q + 10'd1;
               end
            end
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         w_q        <= w_d;
         h_q        <= h_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign pix_ready = (state_q == StStream);
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule
